// File: rtl/mant_div_iter.sv
// Multi-cycle restoring divider for floating-point mantissas.
// Resolves BITS_PER_CYCLE quotient bits per clock and returns the quotient,
// the final shifted partial remainder and a sticky bit for rounding.
module mant_div_iter #(
  parameter int unsigned MANT_W         = 24,
  parameter int unsigned QUOT_W         = 24,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_start,
  input  logic [MANT_W:0]   in_dividend,
  input  logic [MANT_W-1:0] in_divisor,
  output logic              out_busy,
  output logic              out_done,
  output logic [QUOT_W-1:0] out_quotient,
  output logic [MANT_W:0]   out_remainder,
  output logic              out_sticky,
  output logic              out_dbz,
  output logic              out_range_err
);

  localparam int unsigned Steps = QUOT_W / BITS_PER_CYCLE;
  localparam int unsigned CntW  = $clog2(Steps + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]        state_q;
  logic [CntW-1:0]   cnt_q;
  logic [MANT_W+1:0] rem_q;
  logic [MANT_W-1:0] div_q;
  logic [QUOT_W-1:0] quot_q;
  logic [QUOT_W-1:0] quot_out_q;
  logic [MANT_W:0]   rem_out_q;
  logic              dbz_q;
  logic              range_err_q;

  logic [MANT_W+1:0] rem_nxt;
  logic [QUOT_W-1:0] quot_nxt;
  logic [MANT_W+1:0] div_ext;
  logic              range_err_in;

  assign div_ext      = {2'b00, div_q};
  // Dividend at least twice the divisor means the leading quotient bit overflows.
  assign range_err_in = {1'b0, in_dividend} >= {in_divisor, 1'b0};

  // BITS_PER_CYCLE chained restoring steps; the shift drops any overflow past R's width.
  always_comb begin
    rem_nxt  = rem_q;
    quot_nxt = quot_q;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      quot_nxt = quot_nxt << 1;
      if (rem_nxt >= div_ext) begin
        rem_nxt     = (rem_nxt - div_ext) << 1;
        quot_nxt[0] = 1'b1;
      end else begin
        rem_nxt = rem_nxt << 1;
      end
    end
  end

  // Control FSM, datapath registers and result registers.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      quot_q      <= '0;
      quot_out_q  <= '0;
      rem_out_q   <= '0;
      dbz_q       <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_start) begin
            if (in_divisor == '0) begin
              state_q     <= StDone;
              quot_out_q  <= '1;
              rem_out_q   <= in_dividend;
              dbz_q       <= 1'b1;
              range_err_q <= 1'b0;
            end else begin
              state_q     <= StRun;
              rem_q       <= {1'b0, in_dividend};
              div_q       <= in_divisor;
              quot_q      <= '0;
              cnt_q       <= CntW'(Steps);
              dbz_q       <= 1'b0;
              range_err_q <= range_err_in;
            end
          end
        end
        StRun: begin
          rem_q  <= rem_nxt;
          quot_q <= quot_nxt;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            state_q    <= StDone;
            quot_out_q <= quot_nxt;
            rem_out_q  <= rem_nxt[MANT_W:0];
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Status and result outputs.
  always_comb begin
    out_busy      = (state_q == StRun);
    out_done      = (state_q == StDone);
    out_quotient  = quot_out_q;
    out_remainder = rem_out_q;
    out_sticky    = |rem_out_q;
    out_dbz       = dbz_q;
    out_range_err = range_err_q;
  end

endmodule
